tt_um_seg7_monitor_ksandov4: RTL and testbench

TT_UM_SEG7_MONITOR_KSANDOV4 -- requirements
Module: tt_um_seg7_monitor_ksandov4

---
 rtl/tt_um_seg7_monitor_ksandov4_pkg.sv | 23 ++
 rtl/seg7_pattern_decode.sv | 28 ++
 rtl/tt_um_seg7_monitor_ksandov4.sv | 135 +++++++++++++
 tb/tb_tt_um_seg7_monitor_ksandov4.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_seg7_monitor_ksandov4_pkg.sv
// rtl/tt_um_seg7_monitor_ksandov4_pkg.sv - shared types and constants for the seven-segment monitor
package tt_um_seg7_monitor_ksandov4_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int ERR_CNT_W = 8;

  // Segment order {g,f,e,d,c,b,a}, high = lit
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational segment pattern to digit decoder
module seg7_pattern_decode
  import tt_um_seg7_monitor_ksandov4_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/tt_um_seg7_monitor_ksandov4.sv
// rtl/tt_um_seg7_monitor_ksandov4.sv - seven-segment seconds-counter monitor with glitch filter and error tracking
// Optional SEG7_COMMON_ANODE_EN: segment inputs are active-low and inverted at the pin.
module tt_um_seg7_monitor_ksandov4
  import tt_um_seg7_monitor_ksandov4_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  logic [6:0] seg_raw;
`ifdef SEG7_COMMON_ANODE_EN
  assign seg_raw = ~ui_in[6:0];
`else
  assign seg_raw = ui_in[6:0];
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, ena, ui_in[7], uio_in[7:1]};

  logic [6:0] seg_s1, seg_s2, seg_prev, last_acc;
  logic [7:0] stab_cnt;
  logic       clr_s1, clr_s2;
  logic       accept, step;

  // The run counter saturates so a long-held pattern is accepted exactly once
  assign accept = (seg_s2 == seg_prev) && (stab_cnt == STABLE_LAST);
  assign step   = accept && (seg_s2 != last_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1   <= 7'h00;
      seg_s2   <= 7'h00;
      seg_prev <= 7'h00;
      clr_s1   <= 1'b0;
      clr_s2   <= 1'b0;
      stab_cnt <= 8'd0;
      last_acc <= 7'h00;
    end else begin
      seg_s1   <= seg_raw;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      clr_s1   <= uio_in[0];
      clr_s2   <= clr_s1;
      if (seg_s2 != seg_prev) stab_cnt <= 8'd0;
      else if (stab_cnt != STABLE_MAX) stab_cnt <= stab_cnt + 8'd1;
      if (accept) last_acc <= seg_s2;
    end
  end

  logic [3:0] dec_digit;
  logic       dec_valid;

  seg7_pattern_decode u_decode (
    .pattern (seg_s2),
    .digit   (dec_digit),
    .valid   (dec_valid)
  );

  state_t               state, state_nxt;
  logic [3:0]           digit, digit_nxt, digit_inc;
  logic                 seq_flag, seq_nxt, inv_flag, inv_nxt, step_q;
  logic                 seq_evt, inv_evt;
  logic [ERR_CNT_W-1:0] err_cnt, err_nxt, err_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_HUNT;
      digit    <= 4'd0;
      seq_flag <= 1'b0;
      inv_flag <= 1'b0;
      err_cnt  <= '0;
      step_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      digit    <= digit_nxt;
      seq_flag <= seq_nxt;
      inv_flag <= inv_nxt;
      err_cnt  <= err_nxt;
      step_q   <= step;
    end
  end

  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    seq_evt   = 1'b0;
    inv_evt   = 1'b0;
    digit_inc = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    if (step) begin
      case (state)
        ST_HUNT: begin
          if (dec_valid) begin
            state_nxt = ST_LOCKED;
            digit_nxt = dec_digit;
          end else begin
            inv_evt = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!dec_valid) begin
            state_nxt = ST_HUNT;
            inv_evt   = 1'b1;
          end else begin
            digit_nxt = dec_digit;
            seq_evt   = (dec_digit != digit_inc);
          end
        end
        default: state_nxt = ST_HUNT;
      endcase
    end

    // Clear acts first so an error on the same edge still registers
    err_base = clr_s2 ? '0 : err_cnt;
    err_nxt  = ((seq_evt || inv_evt) && (err_base != ERR_MAX)) ? err_base + 1'b1 : err_base;
    seq_nxt  = (seq_flag && !clr_s2) || seq_evt;
    inv_nxt  = (inv_flag && !clr_s2) || inv_evt;
  end

  assign uo_out  = {step_q, inv_flag, seq_flag, (state == ST_LOCKED), digit};
  assign uio_out = err_cnt;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_seg7_monitor_ksandov4.sv
// tb/tb_tt_um_seg7_monitor_ksandov4.sv - self-checking bench for the seven-segment monitor
`timescale 1ns/1ps
module tb_tt_um_seg7_monitor_ksandov4;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  tt_um_seg7_monitor_ksandov4 #(.STABLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int step_seen = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] enc(input logic [6:0] p);
`ifdef SEG7_COMMON_ANODE_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  // Reference model: edge-indexed history of what the pins showed
  int segs[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
  int seg_hist[$];
  int clr_hist[$];
  int m_last = 0, m_digit = 0, m_cnt = 0;
  bit m_locked = 0, m_seq = 0, m_inv = 0, m_step = 0;

  function automatic int seg_at(input int i);
    if (i >= 0) return seg_hist[i];
    if (i >= -3) return 0;
    return -1;
  endfunction

  function automatic int clr_at(input int i);
    return (i >= 0) ? clr_hist[i] : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    int e, p, d;
    bit acc, valid, seq_e, inv_e;
    logic [6:0] raw;
    if (!rst_n) begin
      seg_hist.delete();
      clr_hist.delete();
      m_last = 0; m_digit = 0; m_cnt = 0;
      m_locked = 0; m_seq = 0; m_inv = 0; m_step = 0;
    end else begin
      raw = enc(ui_in[6:0]);
      seg_hist.push_back(int'(raw));
      clr_hist.push_back(int'(uio_in[0]));
      e = seg_hist.size() - 1;
      p = seg_at(e - 2);
      // accepted when exactly S+1 identical samples end two edges back
      acc = (seg_at(e - 3 - S) != p);
      for (int k = 1; k <= S; k++) if (seg_at(e - 2 - k) != p) acc = 0;
      m_step = 0; seq_e = 0; inv_e = 0;
      if (acc && p != m_last) begin
        m_step = 1; valid = 0; d = 0;
        for (int j = 0; j < 10; j++) if (segs[j] == p) begin valid = 1; d = j; end
        if (!valid) begin
          inv_e = 1; m_locked = 0;
        end else begin
          if (m_locked && d != (m_digit + 1) % 10) seq_e = 1;
          m_locked = 1; m_digit = d;
        end
      end
      if (acc) m_last = p;
      if (clr_at(e - 2) != 0) begin m_seq = 0; m_inv = 0; m_cnt = 0; end
      if (seq_e) m_seq = 1;
      if (inv_e) m_inv = 1;
      if (seq_e || inv_e) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("uo_out", int'(uo_out), int'({m_step, m_inv, m_seq, m_locked, 4'(m_digit)}));
      check("uio_out", int'(uio_out), m_cnt);
      check("uio_oe", int'(uio_oe), 'hFF);
    end
    if (rst_n && uo_out[7]) step_seen++;
  end

  task automatic hold(input logic [6:0] p, input int n);
    @(negedge clk);
    ui_in = {1'($urandom), enc(p)};
    uio_in[7:1] = 7'($urandom);
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    int base, got, pulses;
    ui_in = {1'b0, enc(7'h00)};
    uio_in = 8'h00;
    rst_n = 1'b0;
    #12;
    check("reset_uo_out", int'(uo_out), 0);
    check("reset_uio_out", int'(uio_out), 0);
    check("reset_uio_oe", int'(uio_oe), 'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    checking = 1'b1;
    hold(7'h00, 12);
    check("dark_no_step", step_seen, 0);

    // Full count 0..9 then wrap to 0
    base = step_seen;
    for (int i = 0; i <= 10; i++) begin
      hold(7'(segs[i % 10]), 20);
      if (i == 0) check("first_lock", int'(uo_out[4:0]), 'h10);
    end
    check("count_steps", step_seen - base, 11);
    check("count_final", int'(uo_out[6:0]), 'h10);
    check("count_errcnt", int'(uio_out), 0);

    // Skip from 2 to 4
    hold(7'h06, 20);
    hold(7'h5B, 20);
    hold(7'h66, 20);
    check("skip_uo", int'(uo_out[6:0]), 'h34);
    check("skip_cnt", int'(uio_out), 1);

    // Clear, then invalid pattern drops lock, then relock on 4
    uio_in[0] = 1'b1;
    hold(7'h66, 4);
    uio_in[0] = 1'b0;
    hold(7'h66, 4);
    check("clear_flags", int'(uo_out[6:0]), 'h14);
    hold(7'h11, 20);
    check("invalid_uo", int'(uo_out[6:0]), 'h44);
    check("invalid_cnt", int'(uio_out), 1);
    hold(7'h66, 20);
    check("relock_uo", int'(uo_out[6:0]), 'h54);
    check("relock_cnt", int'(uio_out), 1);

    // Toggling faster than the filter never steps; then a settled value does
    base = step_seen;
    for (int i = 0; i < 17; i++) hold((i % 2 == 0) ? 7'h06 : 7'h5B, 3);
    check("toggle_no_step", step_seen - base, 0);
    @(negedge clk);
    ui_in = {1'b0, enc(7'h5B)};
    got = -1; pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (uo_out[7]) begin pulses++; if (got < 0) got = i; end
    end
    check("settle_latency", got, S + 2);
    check("pulse_width", pulses, 1);

    // Saturate the error counter, then clear it through the synchronizer
    for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h3F : 7'h5B, 7);
    check("sat_cnt", int'(uio_out), 255);
    @(negedge clk);
    uio_in[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("clear_not_yet", int'(uio_out), 255);
    @(posedge clk); #1;
    check("clear_cnt", int'(uio_out), 0);
    check("clear_flags_sat", int'(uo_out[6:5]), 0);
    @(negedge clk);
    uio_in[0] = 1'b0;

    // Asynchronous reset in the middle of a filter run
    hold(7'h06, 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_uo", int'(uo_out), 0);
    check("async_rst_uio", int'(uio_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = step_seen;
    hold(7'h3F, 20);
    check("post_rst_lock", int'(uo_out[6:0]), 'h10);
    check("post_rst_step", step_seen - base, 1);

    // Randomised traffic with occasional clears and one mid-run reset
    for (int it = 0; it < 160; it++) begin
      logic [6:0] p;
      if ($urandom_range(0, 9) < 7) p = 7'(segs[$urandom_range(0, 9)]);
      else p = 7'($urandom);
      if ($urandom_range(0, 15) == 0) uio_in[0] = 1'b1;
      if (it == 80) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      hold(p, $urandom_range(1, 12));
      uio_in[0] = 1'b0;
    end
    hold(7'h3F, 10);

    checking = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
